// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus saturating direction counters,
// with optional gshare counter indexing enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                pred_taken_o,
  output logic [XLEN-1:0]     pred_target_o,
  output logic [GHR_BITS-1:0] pred_hist_o,
  input  logic                upd_valid_i,
  input  logic [XLEN-1:0]     upd_pc_i,
  input  logic                upd_taken_i,
  input  logic [XLEN-1:0]     upd_target_i,
  input  logic                upd_pred_taken_i,
  input  logic [XLEN-1:0]     upd_pred_target_i,
  input  logic [GHR_BITS-1:0] upd_hist_i,
  output logic                flush_o,
  output logic [XLEN-1:0]     recover_pc_o,
  output logic [31:0]         br_count_o,
  output logic [31:0]         mis_count_o
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [31:0]         PERF_MAX = 32'hFFFF_FFFF;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic [31:0]         r_br_cnt;
  logic [31:0]         r_mis_cnt;

  logic [IDX-1:0]      w_bidx;
  logic [IDX-1:0]      w_cidx;
  logic [TAG_BITS-1:0] w_tag;
  logic [IDX-1:0]      w_upd_bidx;
  logic [IDX-1:0]      w_upd_cidx;
  logic [TAG_BITS-1:0] w_upd_tag;
  logic                w_hit;
  logic                w_flush;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic                w_unused;

  assign w_bidx     = pc_i[IDX+1:2];
  assign w_tag      = pc_i[TAG_BITS+IDX+1:IDX+2];
  assign w_upd_bidx = upd_pc_i[IDX+1:2];
  assign w_upd_tag  = upd_pc_i[TAG_BITS+IDX+1:IDX+2];

  // Low alignment bits and high PC bits never reach the tables.
  assign w_unused = ^{pc_i, upd_hist_i};

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;

  assign w_cidx      = w_bidx ^ IDX'(r_ghr);
  assign w_upd_cidx  = w_upd_bidx ^ IDX'(upd_hist_i);
  assign pred_hist_o = r_ghr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ghr <= '0;
    end else if (upd_valid_i) begin
      r_ghr <= (r_ghr << 1) | GHR_BITS'(upd_taken_i);
    end
  end
`else
  assign w_cidx      = w_bidx;
  assign w_upd_cidx  = w_upd_bidx;
  assign pred_hist_o = '0;
`endif

  // Lookup sees pre-edge state, so a same-cycle update to this index is not visible yet.
  assign w_hit         = r_valid[w_bidx] && (r_tag[w_bidx] == w_tag);
  assign pred_taken_o  = w_hit && r_ctr[w_cidx][CTR_BITS-1];
  assign pred_target_o = pred_taken_o ? r_target[w_bidx] : '0;

  assign w_flush = upd_valid_i &&
                   ((upd_taken_i != upd_pred_taken_i) ||
                    (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign flush_o      = w_flush;
  assign recover_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);

  assign w_ctr_cur = r_ctr[w_upd_cidx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_taken_i) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_INIT;
      end
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (upd_valid_i) begin
      r_ctr[w_upd_cidx] <= w_ctr_next;
      // Taken branches allocate on a miss and simply overwrite an aliasing entry.
      if (upd_taken_i) begin
        r_valid[w_upd_bidx]  <= 1'b1;
        r_tag[w_upd_bidx]    <= w_upd_tag;
        r_target[w_upd_bidx] <= upd_target_i;
      end
      if (r_br_cnt != PERF_MAX) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_flush && (r_mis_cnt != PERF_MAX)) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign br_count_o  = r_br_cnt;
  assign mis_count_o = r_mis_cnt;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces static not-taken fetch, where any taken branch resolved in ID flushes IF_ID.
- IF lookup: combinational lookup on the fetch PC returns a predicted direction and target, which the PC mux uses in the same cycle.
- ID update: the stage where branches resolve feeds back the actual outcome. The block flags mispredictions and supplies the recovery PC.
- Perf counters: two saturating counters count resolved branches and mispredictions.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB and counter-table depth; power of 2, ≥4. IDX = log2(ENTRIES).
- TAG_BITS, 8, BTB tag width. Tag = pc[TAG_BITS+IDX+1 : IDX+2].
- CTR_BITS, 2, saturating direction-counter width; ≥1.
- GHR_BITS, 4, global history length; ≤ IDX. Used only with BP_GSHARE_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- pc_i  in  XLEN  fetch PC (lookup).
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  XLEN  predicted target; 0 when not taken.
- pred_hist_o  out  GHR_BITS  history snapshot at lookup; carried down the pipe.
- upd_valid_i  in  1  resolved conditional branch in ID this cycle.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  XLEN  actual taken target.
- upd_pred_taken_i  in  1  prediction made for this branch.
- upd_pred_target_i  in  XLEN  target predicted for this branch.
- upd_hist_i  in  GHR_BITS  pred_hist_o captured for this branch.
- flush_o  out  1  mispredict; flush IF_ID and redirect.
- recover_pc_o  out  XLEN  correct next PC.
- br_count_o  out  32  resolved-branch count.
- mis_count_o  out  32  misprediction count.

Behaviour:
- Storage per BTB entry: valid bit, tag and target register. Direction counters sit in a separate CTR_BITS array of ENTRIES entries.
- Lookup (combinational, reads pre-edge state):
  - bidx = pc_i[IDX+1:2]; cidx = bidx (XOR history with the macro).
  - hit = valid[bidx] & tag match.
  - pred_taken_o = hit & ctr[cidx][MSB]; pred_target_o = pred_taken_o ? target[bidx] : 0.
- Mispredict (combinational, gated by upd_valid_i):
  - flush_o = upd_valid_i & (upd_taken_i≠upd_pred_taken_i | (upd_taken_i & upd_target_i≠upd_pred_target_i)).
  - recover_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4, driven regardless of flush_o.
- Update (posedge, only when upd_valid_i):
  - Counter at update cidx: increment if taken, decrement if not taken; saturate at 0 and 2^CTR_BITS-1.
  - If taken: write valid=1, tag and target=upd_target_i at update bidx. This allocates on a miss and overwrites on an alias.
  - Not-taken: BTB unchanged.
  - br_count_o +1; mis_count_o +1 if flush_o. Both saturate at 0xFFFFFFFF, no wrap.
- Simultaneous lookup and update to the same index: lookup returns old contents; the new value is visible next cycle.
- Reset (any cycle, including mid-update):
  - All valid bits 0; counters 2^(CTR_BITS-1)-1 (weakly not-taken); tags and targets 0; GHR 0; perf counters 0.
  - A pending update in the reset cycle is discarded.
  - Combinational outputs follow the reset state in the next cycle.
- No internal pipeline: lookup latency 0, update latency 1 cycle.

Optional Feature:
BP_GSHARE_EN.
- Defined:
  - GHR_BITS shift register; on upd_valid_i it shifts in upd_taken_i at LSB.
  - Lookup cidx = bidx XOR {0, GHR}; pred_hist_o = GHR.
  - Update cidx = upd bidx XOR {0, upd_hist_i}.
  - BTB indexing unchanged.
- Undefined: no GHR; pred_hist_o = 0; upd_hist_i ignored; cidx = bidx.

Test Plan (ENTRIES=64, TAG_BITS=8, CTR_BITS=2, macro off):
1. Reset, pc_i=0x40 -> pred_taken_o=0, pred_target_o=0, counters 0.
2. Update pc 0x40, taken, target 0x20, pred_taken 0 -> same cycle flush_o=1, recover_pc_o=0x20. Next cycle pc_i=0x40 -> pred_taken_o=1, pred_target_o=0x20; br_count_o=1, mis_count_o=1.
3. Three more taken updates at 0x40 with correct prediction, so ctr saturates at 3 and flush_o=0 each. Then one not-taken with pred 1 -> flush_o=1, recover_pc_o=0x44; ctr=2, still predicts taken.
4. Alias: pc_i=0x1040 (same index 16, different tag) after test 2 -> pred_taken_o=0. A taken update at 0x1040 replaces the entry, so 0x40 then misses.
5. Same cycle: pc_i=0x80 lookup and taken update at 0x80 -> lookup pred_taken_o=0; next cycle pred_taken_o=1.
6. rst_i asserted alongside upd_valid_i after test 3 -> next cycle pc_i=0x40 pred 0, counts 0, update discarded. With BP_GSHARE_EN: same PC, histories 0000 vs 0001 train independent counters.
